// File: rtl/flag_ckpt_reg.sv
// flag_ckpt_reg: condition-flag register with LIFO checkpoint stack; FLAG_BYPASS_EN selects write-through flag_out
module flag_ckpt_reg #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [WIDTH-1:0]           flag_input,
  input  logic                       ckpt_push,
  input  logic                       ckpt_restore,
  input  logic                       ckpt_discard,
  input  logic                       ckpt_err_clr,
  output logic [WIDTH-1:0]           flag_out,
  output logic [WIDTH-1:0]           ckpt_top,
  output logic [$clog2(DEPTH+1)-1:0] depth_cnt,
  output logic                       full,
  output logic                       empty,
  output logic                       ckpt_err
);
  localparam int DW = $clog2(DEPTH+1);
  localparam logic [DW-1:0] DMAX = DW'(DEPTH);

  logic [WIDTH-1:0] flags_q, flags_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];
  logic [DW-1:0]    depth_q, depth_d;
  logic             err_q, err_d;
  logic             multi, do_push, do_restore, do_discard, err_set;

  assign full      = depth_q == DMAX;
  assign empty     = depth_q == '0;
  assign depth_cnt = depth_q;
  assign ckpt_err  = err_q;

  // top of stack is the entry just below depth; zero when empty
  always_comb begin
    ckpt_top = '0;
    for (int i = 0; i < DEPTH; i++)
      if (depth_q == DW'(i + 1)) ckpt_top = stack_q[i];
  end

  // decode stack op legality; a restore survives a multi-op collision, nothing else does
  always_comb begin
    multi      = (32'(ckpt_push) + 32'(ckpt_restore) + 32'(ckpt_discard)) > 32'd1;
    do_restore = ckpt_restore && !empty;
    do_push    = ckpt_push && !multi && !full;
    do_discard = ckpt_discard && !multi && !empty;
    err_set    = multi || (ckpt_push && full) || ((ckpt_restore || ckpt_discard) && empty);
    flags_d    = do_restore ? ckpt_top : en ? flag_input : flags_q;
    depth_d    = do_push ? depth_q + 1'b1 : (do_restore || do_discard) ? depth_q - 1'b1 : depth_q;
    err_d      = err_set ? 1'b1 : ckpt_err_clr ? 1'b0 : err_q;
    for (int i = 0; i < DEPTH; i++)
      stack_d[i] = (do_push && depth_q == DW'(i)) ? flags_q : stack_q[i];
  end

`ifdef FLAG_BYPASS_EN
  // write-through of new flags, suppressed when a restore owns this cycle
  always_comb flag_out = (en && !do_restore) ? flag_input : flags_q;
`else
  // registered flags only
  always_comb flag_out = flags_q;
`endif

  // control state with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= RESET_VAL;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // stack storage needs no reset; entries above depth are invisible
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end
endmodule

// File: tb/tb_flag_ckpt_reg.sv
// tb_flag_ckpt_reg: directed self-checking bench for flag_ckpt_reg
module tb_flag_ckpt_reg;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0, ckpt_push = 1'b0, ckpt_restore = 1'b0, ckpt_discard = 1'b0, ckpt_err_clr = 1'b0;
  logic [3:0] flag_input = '0;
  logic [3:0] flag_out, ckpt_top;
  logic [2:0] depth_cnt;
  logic       full, empty, ckpt_err;
  int         total = 0;
  int         bad = 0;

  flag_ckpt_reg dut (
    .clk(clk), .reset(reset), .en(en), .flag_input(flag_input),
    .ckpt_push(ckpt_push), .ckpt_restore(ckpt_restore), .ckpt_discard(ckpt_discard),
    .ckpt_err_clr(ckpt_err_clr), .flag_out(flag_out), .ckpt_top(ckpt_top),
    .depth_cnt(depth_cnt), .full(full), .empty(empty), .ckpt_err(ckpt_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
    en = 0; ckpt_push = 0; ckpt_restore = 0; ckpt_discard = 0; ckpt_err_clr = 0; flag_input = '0;
  endtask

  task automatic test_reset();
    #3;
    total++; if (flag_out !== 4'b0000) begin bad++; $display("FAIL rst_flag got=%b exp=0000", flag_out); end
    total++; if (depth_cnt !== 3'd0) begin bad++; $display("FAIL rst_depth got=%0d exp=0", depth_cnt); end
    total++; if ({empty, full, ckpt_err} !== 3'b100) begin bad++; $display("FAIL rst_status got=%b exp=100", {empty, full, ckpt_err}); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_push_restore();
    en = 1; flag_input = 4'b1010; cyc();
    total++; if (flag_out !== 4'b1010) begin bad++; $display("FAIL load got=%b exp=1010", flag_out); end
    en = 1; flag_input = 4'b0101; ckpt_push = 1; cyc();
    total++; if (ckpt_top !== 4'b1010) begin bad++; $display("FAIL push_top got=%b exp=1010", ckpt_top); end
    total++; if (flag_out !== 4'b0101) begin bad++; $display("FAIL push_flag got=%b exp=0101", flag_out); end
    total++; if (depth_cnt !== 3'd1) begin bad++; $display("FAIL push_depth got=%0d exp=1", depth_cnt); end
    en = 1; flag_input = 4'b1111; ckpt_restore = 1; cyc();
    total++; if (flag_out !== 4'b1010) begin bad++; $display("FAIL restore_flag got=%b exp=1010", flag_out); end
    total++; if ({depth_cnt, empty, ckpt_err} !== {3'd0, 1'b1, 1'b0}) begin bad++; $display("FAIL restore_state got=%b exp=000_1_0", {depth_cnt, empty, ckpt_err}); end
  endtask

  task automatic test_full_and_async_reset();
    ckpt_push = 1; en = 1; flag_input = 4'b0001; cyc();
    ckpt_push = 1; en = 1; flag_input = 4'b0010; cyc();
    ckpt_push = 1; en = 1; flag_input = 4'b0011; cyc();
    ckpt_push = 1; en = 1; flag_input = 4'b0100; cyc();
    total++; if ({depth_cnt, full, ckpt_err} !== {3'd4, 1'b1, 1'b0}) begin bad++; $display("FAIL full_state got=%b exp=100_1_0", {depth_cnt, full, ckpt_err}); end
    total++; if (ckpt_top !== 4'b0011) begin bad++; $display("FAIL full_top got=%b exp=0011", ckpt_top); end
    ckpt_push = 1; en = 1; flag_input = 4'b0110; cyc();
    total++; if ({depth_cnt, ckpt_err} !== {3'd4, 1'b1}) begin bad++; $display("FAIL overflow_state got=%b exp=100_1", {depth_cnt, ckpt_err}); end
    total++; if (ckpt_top !== 4'b0011) begin bad++; $display("FAIL overflow_top got=%b exp=0011", ckpt_top); end
    total++; if (flag_out !== 4'b0110) begin bad++; $display("FAIL overflow_en got=%b exp=0110", flag_out); end
    ckpt_err_clr = 1; cyc();
    total++; if (ckpt_err !== 1'b0) begin bad++; $display("FAIL err_clr got=%b exp=0", ckpt_err); end
    ckpt_restore = 1; cyc();
    total++; if ({flag_out, depth_cnt, ckpt_top} !== {4'b0011, 3'd3, 4'b0010}) begin bad++; $display("FAIL pop_full got=%b exp=0011_011_0010", {flag_out, depth_cnt, ckpt_top}); end
    #2 reset = 1'b0;
    #1;
    total++; if ({flag_out, depth_cnt, empty, ckpt_top} !== {4'b0000, 3'd0, 1'b1, 4'b0000}) begin bad++; $display("FAIL async_reset got=%b exp=0000_000_1_0000", {flag_out, depth_cnt, empty, ckpt_top}); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_empty_err();
    ckpt_restore = 1; en = 1; flag_input = 4'b0011; cyc();
    total++; if ({flag_out, ckpt_err, depth_cnt} !== {4'b0011, 1'b1, 3'd0}) begin bad++; $display("FAIL empty_restore got=%b exp=0011_1_000", {flag_out, ckpt_err, depth_cnt}); end
    ckpt_err_clr = 1; cyc();
    ckpt_discard = 1; cyc();
    total++; if ({ckpt_err, depth_cnt} !== {1'b1, 3'd0}) begin bad++; $display("FAIL empty_discard got=%b exp=1_000", {ckpt_err, depth_cnt}); end
    ckpt_err_clr = 1; ckpt_restore = 1; cyc();
    total++; if (ckpt_err !== 1'b1) begin bad++; $display("FAIL clr_vs_new_err got=%b exp=1", ckpt_err); end
    ckpt_err_clr = 1; cyc();
    total++; if (ckpt_err !== 1'b0) begin bad++; $display("FAIL err_clr2 got=%b exp=0", ckpt_err); end
  endtask

  task automatic test_multi();
    ckpt_push = 1; en = 1; flag_input = 4'b1001; cyc();
    ckpt_push = 1; en = 1; flag_input = 4'b1100; cyc();
    total++; if ({depth_cnt, ckpt_top, flag_out} !== {3'd2, 4'b1001, 4'b1100}) begin bad++; $display("FAIL two_push got=%b exp=010_1001_1100", {depth_cnt, ckpt_top, flag_out}); end
    ckpt_push = 1; ckpt_discard = 1; cyc();
    total++; if ({depth_cnt, ckpt_err, ckpt_top} !== {3'd2, 1'b1, 4'b1001}) begin bad++; $display("FAIL push_discard got=%b exp=010_1_1001", {depth_cnt, ckpt_err, ckpt_top}); end
    ckpt_restore = 1; ckpt_discard = 1; en = 1; flag_input = 4'b0111; cyc();
    total++; if ({flag_out, depth_cnt, ckpt_err, ckpt_top} !== {4'b1001, 3'd1, 1'b1, 4'b0011}) begin bad++; $display("FAIL restore_discard got=%b exp=1001_001_1_0011", {flag_out, depth_cnt, ckpt_err, ckpt_top}); end
    ckpt_discard = 1; ckpt_err_clr = 1; cyc();
    total++; if ({depth_cnt, ckpt_err, flag_out} !== {3'd0, 1'b0, 4'b1001}) begin bad++; $display("FAIL discard got=%b exp=000_0_1001", {depth_cnt, ckpt_err, flag_out}); end
  endtask

  task automatic test_latency();
    logic [3:0] exp_pre;
`ifdef FLAG_BYPASS_EN
    exp_pre = 4'b1000;
`else
    exp_pre = 4'b1001;
`endif
    @(negedge clk);
    en = 1; flag_input = 4'b1000;
    #1;
    total++; if (flag_out !== exp_pre) begin bad++; $display("FAIL pre_edge got=%b exp=%b", flag_out, exp_pre); end
    cyc();
    total++; if (flag_out !== 4'b1000) begin bad++; $display("FAIL post_edge got=%b exp=1000", flag_out); end
  endtask

  initial begin
    test_reset();
    test_push_restore();
    test_full_and_async_reset();
    test_empty_err();
    test_multi();
    test_latency();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
